// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-master state encoding.
package axi4_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_RESP = 2'b10
    } wr_state_e;

    // True once both the address and data channels have completed for this transaction.
    function automatic logic channels_complete(input logic aw_fin, input logic w_fin);
        return aw_fin && w_fin;
    endfunction

endpackage

// File: rtl/axi4_resp_timer.sv
// Response watchdog: counts cycles spent in SEND/RESP and flags expiry on the limit cycle.
module axi4_resp_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter next state: clear on transaction start, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = {CW{1'b0}};
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/axi4_write_master.sv
// AXI4-Lite single-beat write master, one transaction outstanding.
// Optional response watchdog enabled by defining AXI4_WRITE_MASTER_TIMEOUT_EN.
module axi4_write_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     axi_clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic [ADDRESS_WIDTH-1:0] write_addr,
    output logic                     write_addr_valid,
    input  logic                     write_addr_ready,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_data_valid,
    input  logic                     write_data_ready,
    input  logic [1:0]               write_resp,
    input  logic                     write_resp_valid,
    output logic                     write_resp_ready,
    output logic                     done,
    output logic [1:0]               done_resp,
    output logic                     timeout
);

    wr_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     awv_q, awv_d;
    logic                     wv_q, wv_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic                     done_q, done_d;
    logic [1:0]               done_resp_q, done_resp_d;
    logic                     timeout_q, timeout_d;

    logic                     aw_hs_s;
    logic                     w_hs_s;
    logic                     expired_s;

    assign aw_hs_s = awv_q && write_addr_ready;
    assign w_hs_s  = wv_q && write_data_ready;

`ifdef AXI4_WRITE_MASTER_TIMEOUT_EN
    logic timer_start_s;
    logic timer_run_s;

    assign timer_start_s = (state_q == ST_IDLE) && req_valid;
    assign timer_run_s   = (state_q == ST_SEND) || (state_q == ST_RESP);

    axi4_resp_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_resp_timer (
        .clk_i     (axi_clk),
        .rst_ni    (resetn),
        .start_i   (timer_start_s),
        .run_i     (timer_run_s),
        .expired_o (expired_s)
    );

    assign timeout = timeout_q;
`else
    logic unused_cfg_s;

    assign expired_s    = 1'b0;
    assign timeout      = 1'b0;
    assign unused_cfg_s = (TIMEOUT_CYCLES == 32'd0) ^ timeout_q;
`endif

    // Transaction FSM: next state, channel valids and completion reporting.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        awv_d       = awv_q;
        wv_d        = wv_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    data_d    = req_data;
                    awv_d     = 1'b1;
                    wv_d      = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (aw_hs_s) begin
                    awv_d     = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awv_d = awv_q;
                end
                if (w_hs_s) begin
                    wv_d     = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wv_d = wv_q;
                end
                // A channel finishing on the expiry edge still moves us on to RESP.
                if (channels_complete(aw_done_q || aw_hs_s, w_done_q || w_hs_s)) begin
                    state_d = ST_RESP;
                end else if (expired_s) begin
                    state_d     = ST_IDLE;
                    awv_d       = 1'b0;
                    wv_d        = 1'b0;
                    done_d      = 1'b1;
                    done_resp_d = AXI_RESP_SLVERR;
                    timeout_d   = 1'b1;
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_RESP: begin
                if (write_resp_valid) begin
                    done_d      = 1'b1;
                    done_resp_d = write_resp;
                    state_d     = ST_IDLE;
                end else if (expired_s) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_resp_d = AXI_RESP_SLVERR;
                    timeout_d   = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
                awv_d   = 1'b0;
                wv_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops every valid at once.
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDRESS_WIDTH{1'b0}};
            data_q      <= {DATA_WIDTH{1'b0}};
            awv_q       <= 1'b0;
            wv_q        <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= AXI_RESP_OKAY;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            awv_q       <= awv_d;
            wv_q        <= wv_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign write_resp_ready = (state_q == ST_RESP);
    assign write_addr       = addr_q;
    assign write_data       = data_q;
    assign write_addr_valid = awv_q;
    assign write_data_valid = wv_q;
    assign done             = done_q;
    assign done_resp        = done_resp_q;

endmodule

// File: doc/axi4_write_master.md
# axi4_write_master

AXI4-Lite write master that turns a single-beat write request from an internal requester (core store unit, DMA, or test sequencer) into AXI4-Lite write-address, write-data and write-response channel traffic. It sits directly upstream of the AXI4-Lite write slave and drives that slave's `write_addr`/`write_data` channels while consuming its `write_resp` channel. The block returns a one-cycle completion pulse with the slave's response code. One transaction is outstanding at a time.

## Interface
- `ADDRESS_WIDTH`, 2: width of request and AXI write address.
- `DATA_WIDTH`, 32: width of request and AXI write data.
- `TIMEOUT_CYCLES`, 64: response watchdog limit; used only with `AXI4_WRITE_MASTER_TIMEOUT_EN`.
- `axi_clk` in 1: single clock; all logic on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: write request present.
- `req_ready` out 1: master idle, request accepted on `req_valid && req_ready`.
- `req_addr` in `ADDRESS_WIDTH`: request address.
- `req_data` in `DATA_WIDTH`: request data.
- `write_addr` out `ADDRESS_WIDTH`: AW address.
- `write_addr_valid` out 1: AW valid.
- `write_addr_ready` in 1: AW ready.
- `write_data` out `DATA_WIDTH`: W data.
- `write_data_valid` out 1: W valid.
- `write_data_ready` in 1: W ready.
- `write_resp` in 2: B response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
- `write_resp_valid` in 1: B valid.
- `write_resp_ready` out 1: B ready.
- `done` out 1: one-cycle pulse, transaction finished.
- `done_resp` out 2: response code for the finished transaction; held until the next `done`.
- `timeout` out 1: high with `done` when the watchdog aborted; tied 0 without macro.

## Operation
- States:
  - IDLE: `req_ready`=1. On request handshake, latch `req_addr`/`req_data` into `write_addr`/`write_data`, set both valids, clear `aw_done`/`w_done`, and go to SEND.
  - SEND: AW and W progress independently. On `write_addr_valid && write_addr_ready`, clear `write_addr_valid` and set `aw_done`. W behaves the same way with `w_done`. When both are done, including both in the same edge, go to RESP.
  - RESP: `write_resp_ready`=1. On `write_resp_valid`, latch `done_resp`, pulse `done`, and go to IDLE.
- A valid, once raised, is held with stable address/data until its handshake. The only exception is a watchdog abort.
- `write_resp_valid` seen outside RESP is ignored, because `write_resp_ready`=0 there.
- `req_valid` outside IDLE is ignored. The requester holds it until `req_ready`.
- Reset values (asynchronous, immediate): state IDLE, `req_ready`=1 once IDLE, all valids/readys 0, `write_addr`=0, `write_data`=0, `done`=0, `done_resp`=00, `timeout`=0.
- Reset mid-transaction drops all valids immediately. No response is reported.

## Timing
- Request accepted at edge N. Valids are high from N to N+1.
- With slave ready continuously: AW/W handshake at N+1, `write_resp_ready` high after N+1, B handshake at N+2 if valid, `done` high in cycle N+2..N+3.
- Minimum request-to-request period is 3 cycles. `req_ready` is high in the same cycle as `done`.
- Channel skew is unbounded. RESP is entered the edge after the later handshake.

## Configuration
- `AXI4_WRITE_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entering SEND and increments each cycle in SEND/RESP.
  - When it reaches `TIMEOUT_CYCLES`, the block drops all valids and readys, pulses `done` with `done_resp`=10 and `timeout`=1, and returns to IDLE.
  - A handshake completing on the expiry edge takes priority over the timeout.
- Not defined: no counter, `timeout` tied 0, and the master waits indefinitely.

## Structure
- Shared package `axi4_lite_pkg`: response constants `AXI_RESP_OKAY`/`EXOKAY`/`SLVERR`/`DECERR` and the state encoding (IDLE, SEND, RESP).
- One sub-module is natural: `axi4_resp_timer`, the watchdog counter. It is instantiated only under the macro.

## Test plan
- Req addr 2'b00, data 32'hA5A5A5A5, slave always ready, resp 00 -> AW/W valid for 1 cycle, `done` at 3rd cycle, `done_resp`=00.
- `write_addr_ready` delayed 4 cycles, `write_data_ready` immediate -> W valid drops after 1 cycle, AW held stable 5 cycles, then RESP.
- `write_resp`=11 on addr 2'b11 -> `done_resp`=11, `timeout`=0.
- Back-to-back requests 2'b01/32'h5A5A5A5A and 2'b10/32'h12345678 -> second accepted in the `done` cycle, both completions in order.
- Reset asserted while AW valid pending -> all valids 0 immediately, `done` never pulses, IDLE after release.
- Macro on, `TIMEOUT_CYCLES`=8, B never valid -> `done`=1, `timeout`=1, `done_resp`=10 eight cycles after SEND entry.
